// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port 512x45 SRAM macro between two
// valid/ready requesters (port 0: AXI4-Lite front end, port 1: AES store).
// All macro pins are registered on the rising edge of aclk; the macro runs on
// ~aclk, so read data is back in time for the next rising edge.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; when it is
// undefined, port 1 has fixed priority and no round-robin state exists.
module sram_port_arbiter #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 45
) (
    input  logic          aclk,
    input  logic          aresetn,

    input  logic          p0_req_valid,
    output logic          p0_req_ready,
    input  logic          p0_req_we,
    input  logic [AW-1:0] p0_req_addr,
    input  logic [DW-1:0] p0_req_wdata,
    input  logic [DW-1:0] p0_req_bmask,
    output logic          p0_rsp_valid,
    input  logic          p0_rsp_ready,
    output logic [DW-1:0] p0_rsp_rdata,

    input  logic          p1_req_valid,
    output logic          p1_req_ready,
    input  logic          p1_req_we,
    input  logic [AW-1:0] p1_req_addr,
    input  logic [DW-1:0] p1_req_wdata,
    input  logic [DW-1:0] p1_req_bmask,
    output logic          p1_rsp_valid,
    input  logic          p1_rsp_ready,
    output logic [DW-1:0] p1_rsp_rdata,

    output logic          sram_ceb,
    output logic          sram_web,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    output logic [DW-1:0] sram_bweb,
    input  logic [DW-1:0] sram_q
);

    logic          p0_elig, p1_elig;
    logic          p0_grant, p1_grant;
    logic          issue;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [DW-1:0] sel_bmask;

    // Tag of the access the macro is working on this cycle.
    logic          tag_valid_q;
    logic          tag_port_q;
    logic          tag_read_q;

    // Per-port response slots.
    logic          rsp0_valid_q, rsp1_valid_q;
    logic [DW-1:0] rsp0_data_q, rsp1_data_q;

    logic          load0, load1;
    logic [DW-1:0] cap_data;

`ifdef SRAM_ARB_RR_EN
    logic last_q;

    // Round-robin pointer: most recently granted port, moves only on a handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_q <= 1'b1;
        end else if (issue) begin
            last_q <= p1_grant;
        end
    end
`endif

    // Eligibility and grant; a port may issue while its slot drains this cycle.
    always_comb begin
        p0_elig = p0_req_valid & (~rsp0_valid_q | p0_rsp_ready);
        p1_elig = p1_req_valid & (~rsp1_valid_q | p1_rsp_ready);
`ifdef SRAM_ARB_RR_EN
        p0_grant = p0_elig & (~p1_elig | last_q);
        p1_grant = p1_elig & (~p0_elig | ~last_q);
`else
        p1_grant = p1_elig;
        p0_grant = p0_elig & ~p1_elig;
`endif
    end

    assign p0_req_ready = p0_grant;
    assign p1_req_ready = p1_grant;

    // Select the granted port's request fields.
    always_comb begin
        issue     = p0_grant | p1_grant;
        sel_we    = p1_grant ? p1_req_we    : p0_req_we;
        sel_addr  = p1_grant ? p1_req_addr  : p0_req_addr;
        sel_wdata = p1_grant ? p1_req_wdata : p0_req_wdata;
        sel_bmask = p1_grant ? p1_req_bmask : p0_req_bmask;
    end

    // Macro pin register: drive an access on a handshake, otherwise idle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sram_ceb  <= 1'b1;
            sram_web  <= 1'b1;
            sram_a    <= '0;
            sram_d    <= '0;
            sram_bweb <= '1;
        end else if (issue) begin
            sram_ceb  <= 1'b0;
            sram_web  <= ~sel_we;
            sram_a    <= sel_addr;
            sram_d    <= sel_we ? sel_wdata : '0;
            sram_bweb <= sel_we ? ~sel_bmask : '1;
        end else begin
            sram_ceb  <= 1'b1;
            sram_web  <= 1'b1;
            sram_a    <= '0;
            sram_d    <= '0;
            sram_bweb <= '1;
        end
    end

    // Tag register: which port issued and whether it was a read.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tag_valid_q <= 1'b0;
            tag_port_q  <= 1'b0;
            tag_read_q  <= 1'b0;
        end else begin
            tag_valid_q <= issue;
            tag_port_q  <= issue ? p1_grant : 1'b0;
            tag_read_q  <= issue ? ~sel_we : 1'b0;
        end
    end

    // Capture steering; writes answer with zero data.
    always_comb begin
        load0    = tag_valid_q & ~tag_port_q;
        load1    = tag_valid_q & tag_port_q;
        cap_data = tag_read_q ? sram_q : '0;
    end

    // Port 0 response slot: a load wins over a drain in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
        end else if (load0) begin
            rsp0_valid_q <= 1'b1;
            rsp0_data_q  <= cap_data;
        end else if (rsp0_valid_q && p0_rsp_ready) begin
            rsp0_valid_q <= 1'b0;
        end
    end

    // Port 1 response slot: a load wins over a drain in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
        end else if (load1) begin
            rsp1_valid_q <= 1'b1;
            rsp1_data_q  <= cap_data;
        end else if (rsp1_valid_q && p1_rsp_ready) begin
            rsp1_valid_q <= 1'b0;
        end
    end

    assign p0_rsp_valid = rsp0_valid_q;
    assign p0_rsp_rdata = rsp0_data_q;
    assign p1_rsp_valid = rsp1_valid_q;
    assign p1_rsp_rdata = rsp1_data_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter with a behavioural SRAM macro
// clocked on the falling edge of aclk.
module tb_sram_port_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 45;

    logic          aclk;
    logic          aresetn;
    logic          p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_ready;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_wdata, p0_req_bmask, p0_rsp_rdata;
    logic          p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid, p1_rsp_ready;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_wdata, p1_req_bmask, p1_rsp_rdata;
    logic          sram_ceb, sram_web;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d, sram_bweb;
    logic [DW-1:0] sram_q = '0;

    logic [DW-1:0] mem [512] = '{default: '0};

    int checks = 0;
    int errors = 0;

    localparam logic [DW-1:0] ONES = '1;

    sram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .p0_req_valid (p0_req_valid),
        .p0_req_ready (p0_req_ready),
        .p0_req_we    (p0_req_we),
        .p0_req_addr  (p0_req_addr),
        .p0_req_wdata (p0_req_wdata),
        .p0_req_bmask (p0_req_bmask),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_ready (p0_rsp_ready),
        .p0_rsp_rdata (p0_rsp_rdata),
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_req_we    (p1_req_we),
        .p1_req_addr  (p1_req_addr),
        .p1_req_wdata (p1_req_wdata),
        .p1_req_bmask (p1_req_bmask),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_ready (p1_rsp_ready),
        .p1_rsp_rdata (p1_rsp_rdata),
        .sram_ceb     (sram_ceb),
        .sram_web     (sram_web),
        .sram_a       (sram_a),
        .sram_d       (sram_d),
        .sram_bweb    (sram_bweb),
        .sram_q       (sram_q)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // SRAM macro model, clocked on ~aclk, active-low bit write mask.
    always @(negedge aclk) begin
        if (!sram_ceb) begin
            if (!sram_web) mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_d & ~sram_bweb);
            else           sram_q <= mem[sram_a];
        end
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs;
        p0_req_valid = 0; p0_req_we = 0; p0_req_addr = '0; p0_req_wdata = '0;
        p0_req_bmask = '0; p0_rsp_ready = 0;
        p1_req_valid = 0; p1_req_we = 0; p1_req_addr = '0; p1_req_wdata = '0;
        p1_req_bmask = '0; p1_rsp_ready = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        aresetn = 0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1;
    endtask

    // Full-mask write through port 0, left fully drained afterwards.
    task automatic p0_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        p0_rsp_ready = 1;
        p0_req_valid = 1; p0_req_we = 1; p0_req_addr = addr;
        p0_req_wdata = data; p0_req_bmask = '1;
        tick();
        p0_req_valid = 0; p0_req_we = 0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        clear_inputs();
        aresetn = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++; if (p0_req_ready !== 1'b0) begin errors++;
            $display("FAIL reset_p0_ready: got %b expected 0", p0_req_ready); end
        checks++; if (p1_req_ready !== 1'b0) begin errors++;
            $display("FAIL reset_p1_ready: got %b expected 0", p1_req_ready); end
        checks++; if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) begin errors++;
            $display("FAIL reset_rsp_valid: got %b expected 00", {p0_rsp_valid, p1_rsp_valid}); end
        checks++; if (p0_rsp_rdata !== '0 || p1_rsp_rdata !== '0) begin errors++;
            $display("FAIL reset_rdata: got %h/%h expected 0/0", p0_rsp_rdata, p1_rsp_rdata); end
        checks++; if ({sram_ceb, sram_web} !== 2'b11) begin errors++;
            $display("FAIL reset_ceb_web: got %b expected 11", {sram_ceb, sram_web}); end
        checks++; if (sram_bweb !== ONES) begin errors++;
            $display("FAIL reset_bweb: got %h expected %h", sram_bweb, ONES); end
        checks++; if (sram_a !== '0 || sram_d !== '0) begin errors++;
            $display("FAIL reset_a_d: got %h/%h expected 0/0", sram_a, sram_d); end
        #1;
        aresetn = 1;
    endtask

    task automatic test_write_read;
        logic [DW-1:0] exp_bweb;
        exp_bweb = ~45'h0_0000_FFFF;
        do_reset();
        p0_rsp_ready = 1;
        p0_req_valid = 1; p0_req_we = 1; p0_req_addr = 9'h005;
        p0_req_wdata = 45'h0_1234_5678; p0_req_bmask = 45'h0_0000_FFFF;
        @(negedge aclk);
        checks++; if (p0_req_ready !== 1'b1) begin errors++;
            $display("FAIL wr_ready: got %b expected 1", p0_req_ready); end
        tick();
        checks++; if ({sram_ceb, sram_web} !== 2'b00 || sram_a !== 9'h005) begin errors++;
            $display("FAIL wr_pins: got ceb/web %b a %h expected 00 005",
                     {sram_ceb, sram_web}, sram_a); end
        checks++; if (sram_bweb !== exp_bweb) begin errors++;
            $display("FAIL wr_bweb: got %h expected %h", sram_bweb, exp_bweb); end
        checks++; if (sram_d !== 45'h0_1234_5678) begin errors++;
            $display("FAIL wr_d: got %h expected %h", sram_d, 45'h0_1234_5678); end
        p0_req_we = 0; p0_req_wdata = '0; p0_req_bmask = '0;
        @(negedge aclk);
        checks++; if (p0_req_ready !== 1'b1) begin errors++;
            $display("FAIL rd_ready: got %b expected 1", p0_req_ready); end
        tick();
        checks++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== '0) begin errors++;
            $display("FAIL wr_rsp: got valid %b data %h expected 1 0", p0_rsp_valid, p0_rsp_rdata); end
        checks++; if ({sram_ceb, sram_web} !== 2'b01 || sram_bweb !== ONES || sram_d !== '0)
            begin errors++;
            $display("FAIL rd_pins: got ceb/web %b bweb %h d %h expected 01 all-ones 0",
                     {sram_ceb, sram_web}, sram_bweb, sram_d); end
        p0_req_valid = 0;
        tick();
        checks++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 45'h0_0000_5678) begin errors++;
            $display("FAIL rd_rsp: got valid %b data %h expected 1 %h",
                     p0_rsp_valid, p0_rsp_rdata, 45'h0_0000_5678); end
        checks++; if (sram_ceb !== 1'b1) begin errors++;
            $display("FAIL idle_ceb: got %b expected 1", sram_ceb); end
        tick();
        checks++; if (p0_rsp_valid !== 1'b0) begin errors++;
            $display("FAIL rd_rsp_clear: got %b expected 0", p0_rsp_valid); end
    endtask

    task automatic test_contention;
        logic [1:0] exp_grant;
        int n0, n1, exp0, exp1;
        n0 = 0; n1 = 0;
        do_reset();
        p0_rsp_ready = 1; p1_rsp_ready = 1;
        p0_req_addr = 9'h010; p1_req_addr = 9'h020;
        for (int i = 0; i < 7; i++) begin
            p0_req_valid = (i < 4); p1_req_valid = (i < 4);
            @(negedge aclk);
            if (i < 4) begin
`ifdef SRAM_ARB_RR_EN
                exp_grant = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
                exp_grant = 2'b10;
`endif
                checks++; if ({p1_req_ready, p0_req_ready} !== exp_grant) begin errors++;
                    $display("FAIL contention_grant[%0d]: got %b expected %b",
                             i, {p1_req_ready, p0_req_ready}, exp_grant); end
            end
            if (p0_rsp_valid) n0++;
            if (p1_rsp_valid) n1++;
            tick();
        end
`ifdef SRAM_ARB_RR_EN
        exp0 = 2; exp1 = 2;
`else
        exp0 = 0; exp1 = 4;
`endif
        checks++; if (n0 !== exp0 || n1 !== exp1) begin errors++;
            $display("FAIL contention_rsp_count: got %0d/%0d expected %0d/%0d", n0, n1, exp0, exp1); end
        clear_inputs();
    endtask

    task automatic test_backpressure;
        do_reset();
        p0_write(9'h030, 45'h0A5A_5A5A_5A5A);
        p0_write(9'h031, 45'h1234_5678_9ABC);
        p0_req_addr = 9'h040; p0_rsp_ready = 1;
        p1_req_valid = 1; p1_req_we = 0; p1_req_addr = 9'h030; p1_rsp_ready = 0;
        @(negedge aclk);
        checks++; if (p1_req_ready !== 1'b1) begin errors++;
            $display("FAIL bp_first_grant: got %b expected 1", p1_req_ready); end
        tick();
        p1_req_valid = 0; p0_req_valid = 1;
        tick();
        p1_req_valid = 1; p1_req_addr = 9'h031;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            checks++; if ({p1_rsp_valid, p1_req_ready, p0_req_ready} !== 3'b101) begin errors++;
                $display("FAIL bp_hold[%0d]: got rsp_v/rdy1/rdy0 %b expected 101",
                         i, {p1_rsp_valid, p1_req_ready, p0_req_ready}); end
            checks++; if (p1_rsp_rdata !== 45'h0A5A_5A5A_5A5A) begin errors++;
                $display("FAIL bp_data[%0d]: got %h expected %h",
                         i, p1_rsp_rdata, 45'h0A5A_5A5A_5A5A); end
            tick();
        end
        p1_rsp_ready = 1;
        @(negedge aclk);
        checks++; if (p1_req_ready !== 1'b1) begin errors++;
            $display("FAIL bp_resume: got %b expected 1", p1_req_ready); end
        tick();
        p1_req_valid = 0; p0_req_valid = 0;
        tick();
        @(negedge aclk);
        checks++; if (p1_rsp_valid !== 1'b1 || p1_rsp_rdata !== 45'h1234_5678_9ABC) begin errors++;
            $display("FAIL bp_second_rsp: got valid %b data %h expected 1 %h",
                     p1_rsp_valid, p1_rsp_rdata, 45'h1234_5678_9ABC); end
        clear_inputs();
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp_data [3];
        exp_data[0] = 45'h0000_0000_0111;
        exp_data[1] = 45'h1000_0000_0222;
        exp_data[2] = 45'h0ABC_DEF0_1333;
        do_reset();
        for (int i = 0; i < 3; i++) p0_write(9'h050 + 9'(i), exp_data[i]);
        p0_rsp_ready = 1; p0_req_we = 0;
        for (int i = 0; i < 6; i++) begin
            p0_req_valid = (i < 3);
            p0_req_addr = 9'h050 + 9'(i);
            @(negedge aclk);
            if (i < 3) begin
                checks++; if (p0_req_ready !== 1'b1) begin errors++;
                    $display("FAIL b2b_grant[%0d]: got %b expected 1", i, p0_req_ready); end
            end
            if (i >= 2 && i < 5) begin
                checks++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== exp_data[i-2]) begin
                    errors++;
                    $display("FAIL b2b_rsp[%0d]: got valid %b data %h expected 1 %h",
                             i, p0_rsp_valid, p0_rsp_rdata, exp_data[i-2]); end
            end
            if (i == 5) begin
                checks++; if (p0_rsp_valid !== 1'b0) begin errors++;
                    $display("FAIL b2b_end: got %b expected 0", p0_rsp_valid); end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid;
        do_reset();
        p0_rsp_ready = 1; p0_req_valid = 1; p0_req_we = 0; p0_req_addr = 9'h050;
        @(negedge aclk);
        checks++; if (p0_req_ready !== 1'b1) begin errors++;
            $display("FAIL rst_mid_grant: got %b expected 1", p0_req_ready); end
        tick();
        @(negedge aclk);
        aresetn = 0;
        p0_req_valid = 0;
        tick();
        tick();
        aresetn = 1;
        @(negedge aclk);
        checks++; if ({sram_ceb, sram_web} !== 2'b11 || sram_bweb !== ONES || sram_a !== '0)
            begin errors++;
            $display("FAIL rst_mid_pins: got ceb/web %b bweb %h a %h expected 11 all-ones 0",
                     {sram_ceb, sram_web}, sram_bweb, sram_a); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (p0_rsp_valid !== 1'b0) begin errors++;
                $display("FAIL rst_mid_no_rsp[%0d]: got %b expected 0", i, p0_rsp_valid); end
            tick();
            @(negedge aclk);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        aresetn = 0;
        test_reset();
        test_write_read();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
